// File: rtl/config_pkg.sv
// rtl/config_pkg.sv - elaborated core configuration record published by the discovery table
package config_pkg;

    typedef struct packed {
        logic          RVF;
        logic          RVD;
        logic          RVA;
        logic          RVB;
        logic          RVC;
        logic          RVH;
        logic          RVV;
        logic          RVZCB;
        logic          RVZCMP;
        logic          RVZiCond;
        logic          CvxifEn;
        logic          MmuPresent;
        logic          RVS;
        logic          RVU;
        logic          DebugEn;
        logic          PerfCounterEn;
        logic [31:0]   XLEN;
        logic [31:0]   VLEN;
        logic [31:0]   NrCommitPorts;
        logic [31:0]   NrScoreboardEntries;
        logic [31:0]   IcacheByteSize;
        logic [31:0]   IcacheSetAssoc;
        logic [31:0]   IcacheLineWidth;
        logic [31:0]   DcacheByteSize;
        logic [31:0]   DcacheSetAssoc;
        logic [31:0]   DcacheLineWidth;
        logic [31:0]   DCacheType;
        logic [31:0]   RASDepth;
        logic [31:0]   BTBEntries;
        logic [31:0]   BHTEntries;
        logic [31:0]   NrPMPEntries;
        logic [31:0]   NrNonIdempotentRules;
        logic [1023:0] NonIdempotentAddrBase;
        logic [1023:0] NonIdempotentLength;
        logic [31:0]   NrExecuteRegionRules;
        logic [1023:0] ExecuteRegionAddrBase;
        logic [1023:0] ExecuteRegionLength;
        logic [31:0]   NrCachedRegionRules;
        logic [1023:0] CachedRegionAddrBase;
        logic [1023:0] CachedRegionLength;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '0;

endpackage

// File: rtl/cva6_cfg_discovery.sv
// rtl/cva6_cfg_discovery.sv - read-only configuration discovery table with 2-entry response FIFO
module cva6_cfg_discovery #(
    parameter config_pkg::cva6_cfg_t CVA6Cfg   = config_pkg::cva6_cfg_empty,
    parameter int unsigned           AddrWidth = 12
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_i,
    input  logic                 we_i,
    input  logic [AddrWidth-1:0] addr_i,
    output logic                 gnt_o,
    output logic                 rvalid_o,
    input  logic                 rready_i,
    output logic [63:0]          rdata_o,
    output logic                 err_o,
    output logic [7:0]           err_cnt_o
);

    localparam int unsigned IdxW = AddrWidth - 3;

    logic [IdxW-1:0] widx;
    logic [2:0]      grp;
    logic [3:0]      ent;
    logic [63:0]     rd_word;
    logic            rd_err;

    logic [64:0]     mem [2];
    logic            rd_ptr;
    logic            wr_ptr;
    logic [1:0]      count;
    logic            push;
    logic            pop;

    assign widx = addr_i[AddrWidth-1:3];
    assign grp  = widx[6:4];
    assign ent  = widx[3:0];

    // Region tables hold 16 entries of 64 bits; entries past the rule count read as zero.
    function automatic logic [63:0] region_word(input logic [1023:0] tbl,
                                                input logic [31:0]   nr,
                                                input logic [3:0]    e);
        logic [63:0] w;
        w = '0;
        if ({28'd0, e} < nr) begin
            w = tbl[{e, 6'b0} +: 64];
        end
        return w;
    endfunction

    // Decode the requested word; errors always return zero data.
    always_comb begin
        rd_word = '0;
        rd_err  = 1'b0;
        if (we_i || (addr_i[2:0] != 3'd0) || (32'(widx) >= 32'h70)) begin
            rd_err = 1'b1;
        end else begin
            case (grp)
                3'd0: begin
                    case (ent)
                        4'h0: rd_word = {32'h1, 32'h4356_4136};
                        4'h1: rd_word = {48'd0,
                                         CVA6Cfg.PerfCounterEn, CVA6Cfg.DebugEn, CVA6Cfg.RVU,
                                         CVA6Cfg.RVS, CVA6Cfg.MmuPresent, CVA6Cfg.CvxifEn,
                                         CVA6Cfg.RVZiCond, CVA6Cfg.RVZCMP, CVA6Cfg.RVZCB,
                                         CVA6Cfg.RVV, CVA6Cfg.RVH, CVA6Cfg.RVC, CVA6Cfg.RVB,
                                         CVA6Cfg.RVA, CVA6Cfg.RVD, CVA6Cfg.RVF};
                        4'h2: rd_word = {16'd0,
                                         CVA6Cfg.NrScoreboardEntries[7:0],
                                         CVA6Cfg.NrCommitPorts[7:0],
                                         CVA6Cfg.VLEN[15:0],
                                         CVA6Cfg.XLEN[15:0]};
                        4'h3: rd_word = {8'd0,
                                         CVA6Cfg.IcacheLineWidth[15:0],
                                         CVA6Cfg.IcacheSetAssoc[7:0],
                                         CVA6Cfg.IcacheByteSize};
                        4'h4: rd_word = {CVA6Cfg.DCacheType[7:0],
                                         CVA6Cfg.DcacheLineWidth[15:0],
                                         CVA6Cfg.DcacheSetAssoc[7:0],
                                         CVA6Cfg.DcacheByteSize};
                        4'h5: rd_word = {16'd0,
                                         CVA6Cfg.NrPMPEntries[7:0],
                                         CVA6Cfg.BHTEntries[15:0],
                                         CVA6Cfg.BTBEntries[15:0],
                                         CVA6Cfg.RASDepth[7:0]};
                        default: rd_word = '0;
                    endcase
                end
                3'd1: rd_word = region_word(CVA6Cfg.NonIdempotentAddrBase, CVA6Cfg.NrNonIdempotentRules, ent);
                3'd2: rd_word = region_word(CVA6Cfg.NonIdempotentLength,   CVA6Cfg.NrNonIdempotentRules, ent);
                3'd3: rd_word = region_word(CVA6Cfg.ExecuteRegionAddrBase, CVA6Cfg.NrExecuteRegionRules, ent);
                3'd4: rd_word = region_word(CVA6Cfg.ExecuteRegionLength,   CVA6Cfg.NrExecuteRegionRules, ent);
                3'd5: rd_word = region_word(CVA6Cfg.CachedRegionAddrBase,  CVA6Cfg.NrCachedRegionRules,  ent);
                3'd6: rd_word = region_word(CVA6Cfg.CachedRegionLength,    CVA6Cfg.NrCachedRegionRules,  ent);
                default: rd_word = '0;
            endcase
        end
    end

    // Grant only when the FIFO has room; a pop in the same cycle does not free a slot early.
    assign gnt_o    = req_i && (count != 2'd2);
    assign push     = gnt_o;
    assign rvalid_o = (count != 2'd0);
    assign pop      = rvalid_o && rready_i;
    assign rdata_o  = rvalid_o ? mem[rd_ptr][64:1] : 64'd0;
    assign err_o    = rvalid_o ? mem[rd_ptr][0]    : 1'b0;

    // FIFO payload storage; contents are only observed while count says the slot is live.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= {rd_word, rd_err};
        end
    end

    // FIFO pointers, occupancy and saturating error counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            count     <= 2'd0;
            err_cnt_o <= 8'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
            if (push && rd_err && (err_cnt_o != 8'hFF)) begin
                err_cnt_o <= err_cnt_o + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_cva6_cfg_discovery.sv
// tb/tb_cva6_cfg_discovery.sv - scoreboard bench for the configuration discovery responder
module tb_cva6_cfg_discovery;

    localparam config_pkg::cva6_cfg_t CFG = '{
        RVF: 1'b1, RVD: 1'b1, RVA: 1'b1, RVB: 1'b1, RVC: 1'b1, RVH: 1'b1, RVV: 1'b0,
        RVZCB: 1'b1, RVZCMP: 1'b0, RVZiCond: 1'b1, CvxifEn: 1'b1, MmuPresent: 1'b1,
        RVS: 1'b1, RVU: 1'b1, DebugEn: 1'b1, PerfCounterEn: 1'b1,
        XLEN: 32'd64, VLEN: 32'd64, NrCommitPorts: 32'd2, NrScoreboardEntries: 32'd8,
        IcacheByteSize: 32'd16384, IcacheSetAssoc: 32'd4, IcacheLineWidth: 32'd128,
        DcacheByteSize: 32'd32768, DcacheSetAssoc: 32'd8, DcacheLineWidth: 32'd128,
        DCacheType: 32'd1,
        RASDepth: 32'd2, BTBEntries: 32'd32, BHTEntries: 32'h0001_0080, NrPMPEntries: 32'd8,
        NrNonIdempotentRules: 32'd2,
        NonIdempotentAddrBase: {832'h0, 64'h0BAD_0BAD_0BAD_0BAD, 64'h2000_0000, 64'h1000_0000},
        NonIdempotentLength:   {832'h0, 64'h0BAD_0000_0000_0001, 64'h1000, 64'h2000},
        NrExecuteRegionRules: 32'd3,
        ExecuteRegionAddrBase: {768'h0, 64'hDEAD_BEEF_0000_0003, 64'h8000_0000, 64'h1_0000, 64'h0},
        ExecuteRegionLength:   {832'h0, 64'h4000_0000, 64'h1_0000, 64'h1000},
        NrCachedRegionRules: 32'd1,
        CachedRegionAddrBase: {896'h0, 64'hFFFF_0000_0000_0000, 64'h8000_0000},
        CachedRegionLength:   {896'h0, 64'h1234, 64'h4000_0000}
    };

    typedef struct {
        logic [63:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [11:0] addr = '0;
    logic        gnt;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [63:0] rdata;
    logic        err;
    logic [7:0]  err_cnt;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   err_model = 0;

    cva6_cfg_discovery #(.CVA6Cfg(CFG), .AddrWidth(12)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_i(addr),
        .gnt_o(gnt), .rvalid_o(rvalid), .rready_i(rready), .rdata_o(rdata),
        .err_o(err), .err_cnt_o(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic logic [63:0] region(input logic [1023:0] tbl, input logic [31:0] nr, input int i);
        if (i >= int'(nr)) return 64'd0;
        return 64'(tbl >> (64 * i));
    endfunction

    // Reference model: word contents computed from the configuration by plain arithmetic.
    function automatic exp_t model(input logic w, input logic [11:0] a);
        exp_t r;
        int idx;
        longint unsigned v;
        r.data = 64'd0;
        r.err = 1'b0;
        idx = int'(a) / 8;
        if (w || (a % 8) != 0 || idx >= 'h70) begin
            r.err = 1'b1;
            return r;
        end
        v = 0;
        case (idx)
            0: v = 64'h0000_0001_4356_4136;
            1: v = CFG.RVF * 1 + CFG.RVD * 2 + CFG.RVA * 4 + CFG.RVB * 8 + CFG.RVC * 16
                 + CFG.RVH * 32 + CFG.RVV * 64 + CFG.RVZCB * 128 + CFG.RVZCMP * 256
                 + CFG.RVZiCond * 512 + CFG.CvxifEn * 1024 + CFG.MmuPresent * 2048
                 + CFG.RVS * 4096 + CFG.RVU * 8192 + CFG.DebugEn * 16384 + CFG.PerfCounterEn * 32768;
            2: v = 64'(CFG.XLEN % 65536) + 64'(CFG.VLEN % 65536) * 64'h1_0000
                 + 64'(CFG.NrCommitPorts % 256) * 64'h1_0000_0000
                 + 64'(CFG.NrScoreboardEntries % 256) * 64'h100_0000_0000;
            3: v = 64'(CFG.IcacheByteSize) + 64'(CFG.IcacheSetAssoc % 256) * 64'h1_0000_0000
                 + 64'(CFG.IcacheLineWidth % 65536) * 64'h100_0000_0000;
            4: v = 64'(CFG.DcacheByteSize) + 64'(CFG.DcacheSetAssoc % 256) * 64'h1_0000_0000
                 + 64'(CFG.DcacheLineWidth % 65536) * 64'h100_0000_0000
                 + 64'(CFG.DCacheType % 256) * 64'h100_0000_0000_0000;
            5: v = 64'(CFG.RASDepth % 256) + 64'(CFG.BTBEntries % 65536) * 256
                 + 64'(CFG.BHTEntries % 65536) * 64'h100_0000
                 + 64'(CFG.NrPMPEntries % 256) * 64'h100_0000_0000;
            default: begin
                case (idx / 16)
                    1: v = region(CFG.NonIdempotentAddrBase, CFG.NrNonIdempotentRules, idx % 16);
                    2: v = region(CFG.NonIdempotentLength,   CFG.NrNonIdempotentRules, idx % 16);
                    3: v = region(CFG.ExecuteRegionAddrBase, CFG.NrExecuteRegionRules, idx % 16);
                    4: v = region(CFG.ExecuteRegionLength,   CFG.NrExecuteRegionRules, idx % 16);
                    5: v = region(CFG.CachedRegionAddrBase,  CFG.NrCachedRegionRules,  idx % 16);
                    6: v = region(CFG.CachedRegionLength,    CFG.NrCachedRegionRules,  idx % 16);
                    default: v = 0;
                endcase
            end
        endcase
        r.data = v;
        return r;
    endfunction

    // One bus cycle: drive inputs, sample the grant mid-cycle and record what the DUT owes us.
    task automatic cycle(input logic rq, input logic w, input logic [11:0] a, input logic rr,
                         input logic [63:0] ed, input logic ee, output logic g);
        exp_t e;
        req = rq; we = w; addr = a; rready = rr;
        @(negedge clk); #1;
        g = gnt;
        if (g) begin
            e.data = ed;
            e.err = ee;
            exp_q.push_back(e);
            if (ee && err_model < 255) err_model++;
        end
        @(posedge clk); #1;
    endtask

    task automatic mcycle(input logic rq, input logic w, input logic [11:0] a, input logic rr,
                          output logic g);
        exp_t m;
        m = model(w, a);
        cycle(rq, w, a, rr, m.data, m.err, g);
    endtask

    task automatic drain();
        logic g;
        for (int k = 0; k < 8 && exp_q.size() != 0; k++) cycle(1'b0, 1'b0, 12'h0, 1'b1, 64'd0, 1'b0, g);
        check("drain_empty", 65'(exp_q.size()), 65'd0);
    endtask

    // Monitor: compares every consumed response against the scoreboard and checks hold stability.
    logic        hold = 1'b0;
    logic [64:0] held;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                check("hold_valid", 65'(rvalid), 65'd1);
                check("hold_data", {rdata, err}, held);
            end
            if (rvalid && rready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_resp: got data %h err %b expected no response", rdata, err);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_data", 65'(rdata), 65'(e.data));
                    check("resp_err", 65'(err), 65'(e.err));
                end
            end
            hold = rvalid && !rready;
            held = {rdata, err};
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic g;
        logic gx [4];
        exp_t m;
        // Reset state and combinational grant with an empty FIFO.
        #1;
        check("rst_rvalid", 65'(rvalid), 65'd0);
        check("rst_rdata", 65'(rdata), 65'd0);
        check("rst_err", 65'(err), 65'd0);
        check("rst_err_cnt", 65'(err_cnt), 65'd0);
        req = 1'b1; #1;
        check("rst_gnt_req1", 65'(gnt), 65'd1);
        req = 1'b0; #1;
        check("rst_gnt_req0", 65'(gnt), 65'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // First read: grant in cycle N, response in cycle N+1.
        check("lat_idle_rvalid", 65'(rvalid), 65'd0);
        cycle(1'b1, 1'b0, 12'h000, 1'b1, 64'h0000_0001_4356_4136, 1'b0, g);
        check("lat_gnt", 65'(g), 65'd1);
        req = 1'b0;
        check("lat_rvalid", 65'(rvalid), 65'd1);

        // Directed reads of known words.
        cycle(1'b1, 1'b0, 12'h008, 1'b1, 64'hFEBF, 1'b0, g);
        cycle(1'b1, 1'b0, 12'h188, 1'b1, 64'h1_0000, 1'b0, g);
        cycle(1'b1, 1'b0, 12'h198, 1'b1, 64'h0, 1'b0, g);
        cycle(1'b1, 1'b0, 12'h300, 1'b1, 64'h4000_0000, 1'b0, g);
        cycle(1'b1, 1'b0, 12'h308, 1'b1, 64'h0, 1'b0, g);
        cycle(1'b1, 1'b0, 12'h050, 1'b1, 64'h0, 1'b0, g);
        drain();

        // Error responses.
        cycle(1'b1, 1'b1, 12'h000, 1'b1, 64'h0, 1'b1, g);
        cycle(1'b1, 1'b0, 12'h004, 1'b1, 64'h0, 1'b1, g);
        cycle(1'b1, 1'b0, 12'h380, 1'b1, 64'h0, 1'b1, g);
        check("err_cnt_3", 65'(err_cnt), 65'd3);
        mcycle(1'b1, 1'b0, 12'h010, 1'b1, g);
        drain();

        // Backpressure: two grants then stall; no bypass when full.
        mcycle(1'b1, 1'b0, 12'h018, 1'b0, gx[0]);
        mcycle(1'b1, 1'b0, 12'h020, 1'b0, gx[1]);
        mcycle(1'b1, 1'b0, 12'h028, 1'b0, gx[2]);
        mcycle(1'b1, 1'b0, 12'h028, 1'b0, gx[3]);
        check("bp_gnt0", 65'(gx[0]), 65'd1);
        check("bp_gnt1", 65'(gx[1]), 65'd1);
        check("bp_gnt2", 65'(gx[2]), 65'd0);
        check("bp_gnt3", 65'(gx[3]), 65'd0);
        mcycle(1'b1, 1'b0, 12'h028, 1'b1, g);
        check("bp_no_bypass", 65'(g), 65'd0);
        mcycle(1'b1, 1'b0, 12'h028, 1'b1, g);
        check("bp_resume", 65'(g), 65'd1);
        drain();

        // Error counter saturation.
        for (int k = 0; k < 260; k++) cycle(1'b1, 1'b1, 12'h000, 1'b1, 64'h0, 1'b1, g);
        drain();
        check("sat_255", 65'(err_cnt), 65'd255);
        cycle(1'b1, 1'b0, 12'h001, 1'b1, 64'h0, 1'b1, g);
        drain();
        check("sat_hold", 65'(err_cnt), 65'd255);

        // Reset with two buffered responses.
        mcycle(1'b1, 1'b0, 12'h000, 1'b0, g);
        mcycle(1'b1, 1'b0, 12'h008, 1'b0, g);
        req = 1'b0;
        check("pre_rst_rvalid", 65'(rvalid), 65'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_rvalid", 65'(rvalid), 65'd0);
        check("mid_rst_err_cnt", 65'(err_cnt), 65'd0);
        exp_q.delete();
        err_model = 0;
        @(posedge clk); @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) cycle(1'b0, 1'b0, 12'h0, 1'b1, 64'h0, 1'b0, g);
        check("post_rst_rvalid", 65'(rvalid), 65'd0);

        // Randomized traffic against the reference model.
        for (int k = 0; k < 500; k++) begin
            logic [11:0] a;
            int r;
            r = $urandom_range(0, 15);
            a = 12'($urandom_range(0, 'h7F) * 8);
            if (r == 0) a = 12'($urandom);
            else if (r == 1) a[2:0] = 3'($urandom_range(1, 7));
            mcycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0), a,
                   1'($urandom_range(0, 3) != 0), g);
        end
        drain();
        check("rand_err_cnt", 65'(err_cnt), 65'(err_model));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cva6_cfg_discovery.md
# cva6_cfg_discovery

Read-only responder that publishes the elaborated CVA6 configuration (`config_pkg::cva6_cfg_t`) as a memory-mapped table of 64-bit words. Software and the debug module use it to discover ISA extensions, cache geometry, predictor sizing and PMA regions at run time. It sits behind the peripheral crossbar on a simple req/gnt/rvalid port and holds no state other than its response buffer and error counter.

## Interface
- `CVA6Cfg`, `config_pkg::cva6_cfg_empty`: elaborated core configuration being published.
- `AddrWidth`, 12: byte-address width; word index is `addr_i[AddrWidth-1:3]`.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `req_i`  in  1  request valid.
- `we_i`  in  1  write request.
- `addr_i`  in  AddrWidth  byte address.
- `gnt_o`  out  1  request accepted this cycle.
- `rvalid_o`  out  1  response valid.
- `rready_i`  in  1  response consumed.
- `rdata_o`  out  64  response data; 0 on error.
- `err_o`  out  1  response is an error.
- `err_cnt_o`  out  8  saturating count of error responses.

## Operation
- Word map (unlisted bits read 0):
  - 0x00: `{32'h1, 32'h4356_4136}` (layout version 1, "CVA6").
  - 0x01: features [0]RVF [1]RVD [2]RVA [3]RVB [4]RVC [5]RVH [6]RVV [7]RVZCB [8]RVZCMP [9]RVZiCond [10]CvxifEn [11]MmuPresent [12]RVS [13]RVU [14]DebugEn [15]PerfCounterEn.
  - 0x02: [15:0]XLEN [31:16]VLEN [39:32]NrCommitPorts [47:40]NrScoreboardEntries.
  - 0x03: [31:0]IcacheByteSize [39:32]IcacheSetAssoc [55:40]IcacheLineWidth.
  - 0x04: same fields for Dcache, [63:56]DCacheType.
  - 0x05: [7:0]RASDepth [23:8]BTBEntries [39:24]BHTEntries [47:40]NrPMPEntries.
  - 0x06–0x0F: reserved; read 0, no error.
  - 0x10+i / 0x20+i: NonIdempotent base / length entry i (i=0..15, entry i = bits [64i+63:64i]).
  - 0x30+i / 0x40+i: ExecuteRegion base / length.
  - 0x50+i / 0x60+i: CachedRegion base / length.
  - Region entry with i ≥ corresponding `Nr*Rules`: reads 0, no error.
- Error response (rdata 0, err 1): `we_i`=1, `addr_i[2:0]`≠0, or word index ≥ 0x70. No side effect except `err_cnt_o` increment.
- Fields wider than their slot are truncated to the slot's LSBs.
- Response buffer: 2-entry FIFO of `{rdata, err}`, filled on grant; head drives `rvalid_o/rdata_o/err_o`.
- `gnt_o = req_i && (count != 2)`; no bypass when full, even if `rready_i`=1.
- Pop when `rvalid_o && rready_i`. Simultaneous push and pop with count 1 keeps count 1; new entry becomes head next cycle.
- `err_cnt_o` increments when an error entry is pushed; saturates at 255.

## Timing
- Reset (async assert, sync release): FIFO empty, `rvalid_o`=0, `rdata_o`=0, `err_o`=0, `err_cnt_o`=0; `gnt_o` follows `req_i` combinationally (count 0).
- Latency: grant in cycle N, response visible in cycle N+1 at the earliest.
- Throughput: one grant per cycle with `rready_i` held 1.
- Responses return in grant order; `rdata_o/err_o` stable while `rvalid_o && !rready_i`.
- Reset mid-transaction discards buffered responses; no response is issued for them.

## Test plan
- Reset, then read 0x000 with `rready_i`=1 -> `gnt_o`=1 cycle N, `rvalid_o`=1 cycle N+1, `rdata_o`=64'h0000_0001_4356_4136, `err_o`=0.
- Default cv64a6_imafdch_sv39 cfg, read 0x008 -> `rdata_o`=64'hFEBF; read 0x188 -> 64'h1_0000; read 0x198 -> 0; read 0x300 -> 64'h4000_0000.
- Errors: write 0x000, read 0x004, read 0x380 -> three responses `err_o`=1, `rdata_o`=0, `err_cnt_o`=3; subsequent read 0x010 -> `err_o`=0.
- Backpressure: `rready_i`=0, `req_i`=1 for 4 cycles -> exactly 2 grants, third cycle `gnt_o`=0; raise `rready_i` -> responses drain in order, grants resume next cycle.
- Saturation: 260 error requests -> `err_cnt_o`=255 and holds.
- Assert `rst_ni`=0 with 2 buffered responses -> `rvalid_o` drops immediately; after release no stale response appears.
